// File: rtl/sattn_cmd_dispatch.sv
// Command FIFO and in-order dispatcher for the sparse-attention engines, MMIO programmed.
// Define SATTN_DISPATCH_PERF_EN to build per-engine busy-cycle counters.
module sattn_cmd_dispatch #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned NUM_ENG    = 4,
  parameter int unsigned OPC_W      = 8,
  parameter int unsigned TO_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mmio_wen,
  input  logic [ADDR_WIDTH-1:0] mmio_addr,
  input  logic [DATA_WIDTH-1:0] mmio_wdata,
  output logic [DATA_WIDTH-1:0] mmio_rdata,
  output logic [NUM_ENG-1:0]    eng_start,
  output logic [OPC_W-1:0]      eng_opcode,
  input  logic [NUM_ENG-1:0]    eng_done,
  output logic                  busy,
  output logic                  irq
);
  localparam int unsigned PW = $clog2(QDEPTH);
  localparam logic [ADDR_WIDTH-1:0] AddrPush    = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] AddrStatus  = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] AddrDoneCnt = ADDR_WIDTH'(32'h10);
  localparam logic [ADDR_WIDTH-1:0] AddrLastCyc = ADDR_WIDTH'(32'h18);
  localparam logic [ADDR_WIDTH-1:0] AddrTimeout = ADDR_WIDTH'(32'h20);
  localparam logic [ADDR_WIDTH-1:0] AddrCtrl    = ADDR_WIDTH'(32'h28);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StComplete} state_e;

  logic [OPC_W-1:0] q_opc [QDEPTH];
  logic [7:0]       q_eng [QDEPTH];
  logic [15:0]      q_tag [QDEPTH];

  state_e           state_q;
  logic [PW:0]      wr_ptr_q, rd_ptr_q, occ;
  logic [7:0]       cur_eng_q;
  logic [15:0]      cur_tag_q, last_tag_q;
  logic             cur_to_q, last_to_q, ovf_q, err_q, irq_q;
  logic [31:0]      cyc_cnt_q, last_cyc_q, done_cnt_q;
  logic [TO_W-1:0]  to_limit_q;
  logic [NUM_ENG-1:0] eng_start_q, sel_mask;
  logic [OPC_W-1:0] eng_opcode_q;

  logic wr_push, wr_status, wr_timeout, flush;
  logic empty, full, push, pop, head_ok, sel_done, other_done, timeout_hit;
  logic [PW-1:0] rd_idx, wr_idx;
  logic unused_wdata;

  assign unused_wdata = ^mmio_wdata;

  assign wr_push    = mmio_wen && (mmio_addr == AddrPush);
  assign wr_status  = mmio_wen && (mmio_addr == AddrStatus);
  assign wr_timeout = mmio_wen && (mmio_addr == AddrTimeout);
  assign flush      = mmio_wen && (mmio_addr == AddrCtrl) && mmio_wdata[0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign occ    = wr_ptr_q - rd_ptr_q;
  assign empty  = (occ == '0);
  assign full   = (occ == (PW+1)'(QDEPTH));
  assign rd_idx = rd_ptr_q[PW-1:0];
  assign wr_idx = wr_ptr_q[PW-1:0];
  assign push   = wr_push && !full && !flush;
  assign pop    = (state_q == StIdle) && !empty;
  assign head_ok = 32'(q_eng[rd_idx]) < NUM_ENG;

  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < NUM_ENG; i++) sel_mask[i] = (cur_eng_q == 8'(i));
  end

  assign sel_done    = |(eng_done & sel_mask);
  assign other_done  = |(eng_done & ~sel_mask);
  assign timeout_hit = (to_limit_q != '0) && (cyc_cnt_q >= 32'(to_limit_q));

  always_ff @(posedge clk) begin
    if (push) begin
      q_opc[wr_idx] <= mmio_wdata[OPC_W-1:0];
      q_eng[wr_idx] <= mmio_wdata[15:8];
      q_tag[wr_idx] <= mmio_wdata[31:16];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cur_eng_q    <= '0;
      cur_tag_q    <= '0;
      cur_to_q     <= 1'b0;
      last_tag_q   <= '0;
      last_to_q    <= 1'b0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      irq_q        <= 1'b0;
      cyc_cnt_q    <= '0;
      last_cyc_q   <= '0;
      done_cnt_q   <= '0;
      to_limit_q   <= '0;
      eng_start_q  <= '0;
      eng_opcode_q <= '0;
    end else begin
      eng_start_q <= '0;
      irq_q       <= 1'b0;
      if (wr_timeout) to_limit_q <= mmio_wdata[TO_W-1:0];
      // W1C clears come first so a same-cycle set wins.
      if (wr_status && mmio_wdata[3]) ovf_q <= 1'b0;
      if (wr_status && mmio_wdata[4]) err_q <= 1'b0;
      if (wr_push && full && !flush) ovf_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (flush) rd_ptr_q <= wr_ptr_q;
      else if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            cur_eng_q <= q_eng[rd_idx];
            cur_tag_q <= q_tag[rd_idx];
            cur_to_q  <= 1'b0;
            cyc_cnt_q <= '0;
            if (head_ok) begin
              eng_opcode_q <= q_opc[rd_idx];
              state_q      <= StIssue;
            end else begin
              err_q   <= 1'b1;
              state_q <= StComplete;
            end
          end
        end
        StIssue: begin
          eng_start_q <= sel_mask;
          cyc_cnt_q   <= '0;
          state_q     <= StWait;
        end
        StWait: begin
          if (other_done) err_q <= 1'b1;
          if (sel_done) begin
            eng_opcode_q <= '0;
            state_q      <= StComplete;
          end else if (timeout_hit) begin
            cur_to_q     <= 1'b1;
            err_q        <= 1'b1;
            eng_opcode_q <= '0;
            state_q      <= StComplete;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
          end
        end
        StComplete: begin
          done_cnt_q <= done_cnt_q + 1'b1;
          last_cyc_q <= cyc_cnt_q;
          last_tag_q <= cur_tag_q;
          last_to_q  <= cur_to_q;
          irq_q      <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SATTN_DISPATCH_PERF_EN
  logic [63:0] perf_q [NUM_ENG];
  logic        perf_clr;

  assign perf_clr = mmio_wen && (mmio_addr == ADDR_WIDTH'(32'h38));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENG; i++) perf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENG; i++) begin
        if (perf_clr) perf_q[i] <= '0;
        else if (state_q == StWait && sel_mask[i]) perf_q[i] <= perf_q[i] + 64'd1;
      end
    end
  end
`endif

  always_comb begin
    mmio_rdata = '0;
    case (mmio_addr)
      AddrStatus: begin
        mmio_rdata[0]     = busy;
        mmio_rdata[1]     = empty;
        mmio_rdata[2]     = full;
        mmio_rdata[3]     = ovf_q;
        mmio_rdata[4]     = err_q;
        mmio_rdata[15:8]  = 8'(occ);
        mmio_rdata[31:16] = last_tag_q;
        mmio_rdata[32]    = last_to_q;
      end
      AddrDoneCnt: mmio_rdata[31:0] = done_cnt_q;
      AddrLastCyc: mmio_rdata[31:0] = last_cyc_q;
      AddrTimeout: mmio_rdata[TO_W-1:0] = to_limit_q;
      default: ;
    endcase
`ifdef SATTN_DISPATCH_PERF_EN
    for (int i = 0; i < NUM_ENG; i++) begin
      if (mmio_addr == ADDR_WIDTH'(32'h40 + 8 * i)) mmio_rdata = perf_q[i];
    end
`endif
  end

  assign busy       = (state_q != StIdle);
  assign irq        = irq_q;
  assign eng_start  = eng_start_q;
  assign eng_opcode = eng_opcode_q;

endmodule

// File: tb/tb_sattn_cmd_dispatch.sv
// Directed self-checking bench for sattn_cmd_dispatch (default parameters).
module tb_sattn_cmd_dispatch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmio_wen = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [63:0] mmio_wdata = '0;
  logic [63:0] mmio_rdata;
  logic [3:0]  eng_start;
  logic [7:0]  eng_opcode;
  logic [3:0]  eng_done = '0;
  logic        busy;
  logic        irq;

  int checks = 0;
  int failures = 0;
  int start_cnt [4] = '{0, 0, 0, 0};
  int irq_cnt = 0;

  sattn_cmd_dispatch dut (
    .clk        (clk),
    .rst        (rst),
    .mmio_wen   (mmio_wen),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_rdata (mmio_rdata),
    .eng_start  (eng_start),
    .eng_opcode (eng_opcode),
    .eng_done   (eng_done),
    .busy       (busy),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) start_cnt[i] <= start_cnt[i] + int'(eng_start[i]);
    irq_cnt <= irq_cnt + int'(irq);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    mmio_wen   = 1'b1;
    mmio_addr  = a;
    mmio_wdata = d;
    step();
    mmio_wen   = 1'b0;
    mmio_wdata = '0;
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] a, input logic [63:0] mask,
                        input logic [63:0] exp);
    mmio_addr = a;
    #1;
    check(tag, mmio_rdata & mask, exp);
  endtask

  task automatic wait_irq(input string tag, input int budget);
    logic got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (irq) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, {63'd0, got}, 64'd1);
  endtask

  task automatic wait_start(input string tag, input int idx, input int budget);
    logic got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (eng_start[idx]) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, {63'd0, got}, 64'd1);
  endtask

  localparam logic [63:0] All = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int snap;
    logic [63:0] perf_exp;
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_outputs", {52'd0, eng_start, busy, irq, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
          64'd0);
    check("rst_opcode", {56'd0, eng_opcode}, 64'd0);
    chk_rd("rst_status", 16'h08, All, 64'h2);
    chk_rd("rst_done_cnt", 16'h10, All, 64'd0);
    chk_rd("rst_timeout", 16'h20, All, 64'd0);

    // Single command: opc 0x14, engine 1, tag 0xAB, done 10 cycles after start
    wr(16'h00, 64'h00AB_0114);
    step();
    check("t1_issue_no_start", {60'd0, eng_start}, 64'd0);
    check("t1_opcode", {56'd0, eng_opcode}, 64'h14);
    step();
    check("t1_start_onehot", {60'd0, eng_start}, 64'b0010);
    repeat (10) step();
    eng_done = 4'b0010;
    step();
    eng_done = 4'b0000;
    check("t1_irq_not_yet", {63'd0, irq}, 64'd0);
    step();
    check("t1_irq", {62'd0, irq, busy}, 64'b10);
    chk_rd("t1_done_cnt", 16'h10, All, 64'd1);
    chk_rd("t1_last_cyc", 16'h18, All, 64'd10);
    chk_rd("t1_status", 16'h08, All, 64'h00AB_0002);
    step();
    check("t1_irq_once", 64'(irq_cnt), 64'd1);
    check("t1_start_once", 64'(start_cnt[1]), 64'd1);

    // Overflow: six back-to-back pushes to a stalled engine 0
    for (int i = 1; i <= 6; i++) wr(16'h00, 64'(i) << 16);
    chk_rd("t2_status_full_ovf", 16'h08, All, 64'h00AB_040D);
    wr(16'h08, 64'h18);
    chk_rd("t2_w1c", 16'h08, All, 64'h00AB_0405);

    // Watchdog on the stalled tag-1 command
    wr(16'h20, 64'd20);
    chk_rd("t3_timeout_rb", 16'h20, All, 64'd20);
    chk_rd("t3_unmapped", 16'h30, All, 64'd0);
    wait_irq("t3_irq", 60);
    chk_rd("t3_last_cyc", 16'h18, All, 64'd20);
    chk_rd("t3_status", 16'h08, All, 64'h0000_0001_0001_0414);
    chk_rd("t3_done_cnt", 16'h10, All, 64'd2);
    step();
    check("t3_irq_pulse", {63'd0, irq}, 64'd0);
    wait_start("t3_next_dispatch", 0, 10);

    // Flush during WAIT with three queued behind the in-flight tag 2
    chk_rd("t5_occ3", 16'h08, 64'hFF00, 64'h0300);
    wr(16'h28, 64'h1);
    chk_rd("t5_flushed", 16'h08, 64'hFF02, 64'h0002);
    eng_done = 4'b0001;
    step();
    eng_done = 4'b0000;
    wait_irq("t5_irq", 10);
    chk_rd("t5_status", 16'h08, All, 64'h0000_0000_0002_0012);
    chk_rd("t5_last_cyc", 16'h18, All, 64'd1);
    chk_rd("t5_done_cnt", 16'h10, All, 64'd3);
    snap = start_cnt[0];
    repeat (8) step();
    check("t5_no_more_starts", 64'(start_cnt[0]), 64'(snap));
    check("t5_idle", {63'd0, busy}, 64'd0);

    // Out-of-range engine id retires with error and no start
    wr(16'h08, 64'h10);
    snap = start_cnt[0] + start_cnt[1] + start_cnt[2] + start_cnt[3];
    wr(16'h00, 64'h0077_0705);
    wait_irq("t4_irq", 10);
    chk_rd("t4_status", 16'h08, All, 64'h0000_0000_0077_0012);
    chk_rd("t4_done_cnt", 16'h10, All, 64'd4);
    chk_rd("t4_last_cyc", 16'h18, All, 64'd0);
    step();
    check("t4_no_start", 64'(start_cnt[0] + start_cnt[1] + start_cnt[2] + start_cnt[3]),
          64'(snap));

    // Reset in the middle of WAIT on engine 2
    wr(16'h20, 64'd0);
    wr(16'h38, 64'd0);
    wr(16'h00, 64'h0022_0233);
    wait_start("t6_start", 2, 10);
    repeat (5) step();
`ifdef SATTN_DISPATCH_PERF_EN
    perf_exp = 64'd5;
`else
    perf_exp = 64'd0;
`endif
    chk_rd("t6_perf_eng2", 16'h50, All, perf_exp);
    check("t6_busy_opc", {55'd0, busy, eng_opcode}, {55'd0, 1'b1, 8'h33});
    snap = irq_cnt;
    #1 rst = 1'b1;
    #1;
    check("t6_async_outputs", {50'd0, eng_start, busy, irq, eng_opcode}, 64'd0);
    step();
    rst = 1'b0;
    chk_rd("t6_done_cnt", 16'h10, All, 64'd0);
    chk_rd("t6_status", 16'h08, All, 64'h2);
    chk_rd("t6_perf_cleared", 16'h50, All, 64'd0);
    repeat (6) step();
    check("t6_no_irq", 64'(irq_cnt), 64'(snap));
    check("t6_no_restart", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
